// File: rtl/alu_md_control_unit_pkg.sv
// Shared definitions for the EX-stage ALU / RV32M control slice:
// ALU select codes, aluop classes, funct3 codes, MD FSM state encoding
// and the base (non-M) ALU decode helper.
package alu_md_control_unit_pkg;

    // ALU function selects
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    // Operation classes from main control
    localparam logic [2:0] ALUOP_LDST   = 3'd0;
    localparam logic [2:0] ALUOP_BRANCH = 3'd1;
    localparam logic [2:0] ALUOP_R_I    = 3'd2;
    localparam logic [2:0] ALUOP_JALR   = 3'd3;

    // Base funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // M-extension funct3 codes
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // Base RV32I ALU decode, shared by every aluop class
    function automatic logic [3:0] base_alusel(input logic [2:0] aluop,
                                               input logic [2:0] func3,
                                               input logic       func7_5,
                                               input logic       is_rtype);
        logic [3:0] sel;
        sel = ALU_PASS;
        case (aluop)
            ALUOP_LDST, ALUOP_JALR: sel = ALU_ADD;
            ALUOP_BRANCH:           sel = ALU_SUB;
            ALUOP_R_I: begin
                case (func3)
                    F3_ADD_SUB: sel = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     sel = ALU_SLL;
                    F3_SLT:     sel = ALU_SLT;
                    F3_SLTU:    sel = ALU_SLTU;
                    F3_XOR:     sel = ALU_XOR;
                    F3_SRL_SRA: sel = func7_5 ? ALU_SRA : ALU_SRL;
                    F3_OR:      sel = ALU_OR;
                    default:    sel = ALU_AND;
                endcase
            end
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_md_control_unit_if.sv
// EX-stage decode / multiply-divide bus between the pipeline and the
// ALU/MD control block.
interface alu_md_control_unit_if #(parameter int XLEN = 32);
    logic            valid_i;
    logic [2:0]      aluop;
    logic [2:0]      func3;
    logic            func7_5;
    logic            func7_0;
    logic            is_rtype;
    logic            flush;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      alusel;
    logic            md_stall;
    logic            md_sel;
    logic [XLEN-1:0] md_result;

    modport master (
        output valid_i, aluop, func3, func7_5, func7_0, is_rtype, flush, opa, opb,
        input  alusel, md_stall, md_sel, md_result
    );

    modport slave (
        input  valid_i, aluop, func3, func7_5, func7_0, is_rtype, flush, opa, opb,
        output alusel, md_stall, md_sel, md_result
    );
endinterface

// File: rtl/alu_md_control_unit_md_iter_core.sv
// Datapath of the iterative multiply/divide engine: operand magnitude
// capture, radix-2 shift-add multiply, restoring divide, sign fix and the
// divide fast paths. Optional macro MDU_EARLY_OUT_EN lets a multiply finish
// as soon as the remaining multiplier bits are all zero.
import alu_md_control_unit_pkg::*;

module md_iter_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step_mul,
    input  logic            step_div,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            fast,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int W2 = 2 * XLEN;

    logic [W2-1:0]    acc_q, mcand_q, acc_nxt, prod_fix;
    logic [XLEN-1:0]  mplier_q, res_q, abs_a, abs_b, fast_res, quo_fix, rem_fix, res_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic             neg_q, neg_r_q;
    logic             a_signed, b_signed, sa, sb, div0, ovf;
    logic [XLEN:0]    trial, diff;

    // Operand signedness, magnitudes and divide fast-path detection
    always_comb begin
        a_signed = (func3 != F3_MULHU) && (func3 != F3_DIVU) && (func3 != F3_REMU);
        b_signed = (func3 == F3_MUL) || (func3 == F3_MULH) ||
                   (func3 == F3_DIV) || (func3 == F3_REM);
        sa       = a_signed & opa[XLEN-1];
        sb       = b_signed & opb[XLEN-1];
        abs_a    = sa ? -opa : opa;
        abs_b    = sb ? -opb : opb;
        div0     = (opb == '0);
        ovf      = ~func3[0] & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (&opb);
        fast     = func3[2] & (div0 | ovf);
        if (div0) fast_res = func3[1] ? opa : '1;
        else      fast_res = func3[1] ? '0  : opa;
    end

    // One multiply or restoring-divide step plus the signed result it would produce
    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        acc_nxt = acc_q;
        trial   = acc_q[W2-1:XLEN-1];
        diff    = trial - {1'b0, mcand_q[XLEN-1:0]};
        if (step_mul) begin
            acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
        end else if (step_div) begin
            if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
            else             acc_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q   ? -acc_nxt               : acc_nxt;
        quo_fix  = neg_q   ? -acc_nxt[XLEN-1:0]     : acc_nxt[XLEN-1:0];
        rem_fix  = neg_r_q ? -acc_nxt[W2-1:XLEN]    : acc_nxt[W2-1:XLEN];
        if (f3_q[2])              res_nxt = f3_q[1] ? rem_fix : quo_fix;
        else if (f3_q == F3_MUL)  res_nxt = prod_fix[XLEN-1:0];
        else                      res_nxt = prod_fix[W2-1:XLEN];
    end

    // Final-iteration flag
`ifdef MDU_EARLY_OUT_EN
    assign last = (cnt_q == CNT_W'(1)) | (step_mul & (mplier_q[XLEN-1:1] == '0));
`else
    assign last = (cnt_q == CNT_W'(1));
`endif

    // Operand capture on accept, then one iteration per busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (start) begin
            acc_q    <= func3[2] ? {{XLEN{1'b0}}, abs_a} : '0;
            mcand_q  <= {{XLEN{1'b0}}, abs_b};
            mplier_q <= abs_a;
            cnt_q    <= CNT_W'(XLEN);
            f3_q     <= func3;
            neg_q    <= sa ^ sb;
            neg_r_q  <= sa;
            if (fast) res_q <= fast_res;
        end else if (step_mul || step_div) begin
            acc_q    <= acc_nxt;
            mcand_q  <= step_mul ? (mcand_q << 1) : mcand_q;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (last) res_q <= res_nxt;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/alu_md_control_unit.sv
// EX-stage ALU control: combinational RV32I alusel decode plus the FSM
// that sequences the RV32M multiply/divide engine, stalls the pipeline
// while it runs and selects md_result for one cycle when it finishes.
// Optional macro MDU_EARLY_OUT_EN enables multiply early termination.
import alu_md_control_unit_pkg::*;

module alu_md_control_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_md_control_unit_if.slave bus
);
    md_state_t       state_q, state_d;
    logic            md_req, start, fast, last, step_mul, step_div;
    logic [XLEN-1:0] core_res;

    assign md_req   = bus.valid_i & (bus.aluop == ALUOP_R_I) & bus.is_rtype &
                      bus.func7_0 & ~bus.flush;
    assign step_mul = (state_q == MD_MUL);
    assign step_div = (state_q == MD_DIV);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MD_IDLE;
        else        state_q <= state_d;
    end

    // Next state and engine start; flush overrides everything
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_req) begin
                    start = 1'b1;
                    if (fast)           state_d = MD_DONE;
                    else if (bus.func3[2]) state_d = MD_DIV;
                    else                state_d = MD_MUL;
                end
            end
            MD_MUL, MD_DIV: if (last) state_d = MD_DONE;
            default:        state_d = MD_IDLE;
        endcase
        if (bus.flush) state_d = MD_IDLE;
    end

    md_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .step_mul (step_mul),
        .step_div (step_div),
        .func3    (bus.func3),
        .opa      (bus.opa),
        .opb      (bus.opb),
        .fast     (fast),
        .last     (last),
        .result   (core_res)
    );

    assign bus.md_stall  = (state_q == MD_IDLE && md_req) || step_mul || step_div;
    assign bus.md_sel    = (state_q == MD_DONE);
    assign bus.md_result = bus.md_sel ? core_res : '0;
    assign bus.alusel    = md_req ? ALU_PASS
                                  : base_alusel(bus.aluop, bus.func3, bus.func7_5, bus.is_rtype);

endmodule

// File: tb/tb_alu_md_control_unit.sv
// Self-checking bench for alu_md_control_unit (XLEN=32): a cycle-level
// reference model checked every cycle, plus directed vectors with
// hand-computed results and latencies.
import alu_md_control_unit_pkg::*;

module tb_alu_md_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_md_control_unit_if #(.XLEN(32)) bus ();

    alu_md_control_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_A7    = 4;
    localparam int LAT_A2    = 3;
    localparam int LAT_AM1SU = 2;
`else
    localparam int LAT_A7    = 33;
    localparam int LAT_A2    = 33;
    localparam int LAT_AM1SU = 33;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_decode(input logic [2:0] op, input logic [2:0] f3,
                                              input logic f7_5, input logic rt);
        if (op == ALUOP_LDST || op == ALUOP_JALR) return ALU_ADD;
        if (op == ALUOP_BRANCH) return ALU_SUB;
        if (op != ALUOP_R_I) return ALU_PASS;
        case (f3)
            3'd0: return (rt && f7_5) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7_5 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit is_div_op(input logic [2:0] f3);
        return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!is_div_op(f3)) return 1'b0;
        if (b == 0) return 1'b1;
        return (f3 inside {F3_DIV, F3_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        bit sga, sgb, is_rem;
        sga    = f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        sgb    = f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
        is_rem = f3 inside {F3_REM, F3_REMU};
        if (!is_div_op(f3)) begin
            ea = {{32{sga & a[31]}}, a};
            eb = {{32{sgb & b[31]}}, b};
            p  = ea * eb;
            return (f3 == F3_MUL) ? p[31:0] : p[63:32];
        end
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (sga && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : a;
        if (sga) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? a % b : a / b;
    endfunction

    // Number of cycles spent iterating before the result cycle
    function automatic int ref_busy(input logic [2:0] f3, input logic [31:0] a);
`ifdef MDU_EARLY_OUT_EN
        logic [31:0] mag;
        int hb;
        if (!is_div_op(f3)) begin
            mag = (f3 != F3_MULHU && a[31]) ? -a : a;
            hb  = -1;
            for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
            return (hb < 0) ? 1 : hb + 1;
        end
`endif
        return 32 + 0 * int'(f3) + 0 * int'(a[0]);
    endfunction

    int          m_phase = 0;   // 0 idle, 1 iterating, 2 result cycle
    int          m_left  = 0;
    logic [31:0] m_res   = '0;

    always @(negedge clk) begin
        logic req;
        if (!rst_n) m_phase = 0;
        req = bus.valid_i && bus.aluop == ALUOP_R_I && bus.is_rtype && bus.func7_0 && !bus.flush;
        check("model_alusel", bus.alusel,
              req ? ALU_PASS : ref_decode(bus.aluop, bus.func3, bus.func7_5, bus.is_rtype));
        check("model_stall", bus.md_stall, (m_phase == 1) || (m_phase == 0 && req));
        check("model_md_sel", bus.md_sel, m_phase == 2);
        check("model_md_result", bus.md_result, (m_phase == 2) ? m_res : 32'd0);
        if (!rst_n || bus.flush) m_phase = 0;
        else if (m_phase == 0) begin
            if (req) begin
                m_res = ref_result(bus.func3, bus.opa, bus.opb);
                if (ref_fast(bus.func3, bus.opa, bus.opb)) m_phase = 2;
                else begin
                    m_phase = 1;
                    m_left  = ref_busy(bus.func3, bus.opa);
                end
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else m_phase = 0;
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_idle();
        bus.valid_i = 1'b0; bus.aluop = ALUOP_R_I; bus.func3 = 3'd0;
        bus.func7_5 = 1'b0; bus.func7_0 = 1'b0; bus.is_rtype = 1'b1;
        bus.flush = 1'b0; bus.opa = '0; bus.opb = '0;
    endtask

    task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = 1'b1; bus.aluop = ALUOP_R_I; bus.func3 = f3;
        bus.func7_5 = 1'b0; bus.func7_0 = 1'b1; bus.is_rtype = 1'b1;
        bus.flush = 1'b0; bus.opa = a; bus.opb = b;
    endtask

    // Called just after a rising edge; returns just after a rising edge
    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat, stalls;
        bit found;
        lat = 0; stalls = 0; found = 1'b0;
        drive_md(f3, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.md_sel) begin
                found = 1'b1;
                break;
            end
            if (bus.md_stall) stalls++;
            lat++;
        end
        check({name, "_done_seen"}, found, 1'b1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_stall_cycles"}, stalls, exp_lat);
        check({name, "_result"}, bus.md_result, exp_res);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check({name, "_sel_one_cycle"}, bus.md_sel, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic decode_case(input string name, input bit v, input logic [2:0] op,
                               input logic [2:0] f3, input bit f7_5, input bit f7_0,
                               input bit rt, input logic [3:0] exp_sel);
        bus.valid_i = v; bus.aluop = op; bus.func3 = f3;
        bus.func7_5 = f7_5; bus.func7_0 = f7_0; bus.is_rtype = rt;
        @(negedge clk);
        check({name, "_alusel"}, bus.alusel, exp_sel);
        check({name, "_stall"}, bus.md_stall, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        drive_idle();
        #12;
        check("reset_stall", bus.md_stall, 1'b0);
        check("reset_md_sel", bus.md_sel, 1'b0);
        check("reset_md_result", bus.md_result, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain ADD R-type never touches the MD engine
        bus.valid_i = 1'b1; bus.opa = 32'd5; bus.opb = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("add_alusel", bus.alusel, ALU_ADD);
            check("add_stall", bus.md_stall, 1'b0);
            check("add_md_sel", bus.md_sel, 1'b0);
            @(posedge clk); #1;
        end

        decode_case("sub",    1, ALUOP_R_I,    3'd0, 1, 0, 1, ALU_SUB);
        decode_case("addi",   1, ALUOP_R_I,    3'd0, 1, 0, 0, ALU_ADD);
        decode_case("sra",    1, ALUOP_R_I,    3'd5, 1, 0, 1, ALU_SRA);
        decode_case("srl",    1, ALUOP_R_I,    3'd5, 0, 0, 1, ALU_SRL);
        decode_case("sltu",   1, ALUOP_R_I,    3'd3, 0, 0, 0, ALU_SLTU);
        decode_case("load",   1, ALUOP_LDST,   3'd2, 0, 0, 0, ALU_ADD);
        decode_case("branch", 1, ALUOP_BRANCH, 3'd1, 0, 0, 0, ALU_SUB);
        decode_case("jalr",   1, ALUOP_JALR,   3'd0, 0, 0, 0, ALU_ADD);
        decode_case("other",  1, 3'd6,         3'd0, 0, 0, 0, ALU_PASS);
        decode_case("m_inval",0, ALUOP_R_I,    3'd4, 0, 1, 1, ALU_XOR);
        drive_idle();

        run_md("mul_neg",  F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_A7);
        run_md("mul_7x3",  F3_MUL,    32'd7,         32'd3,         32'd21,        LAT_A7);
        run_md("mulh_min", F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_md("mulhu_max",F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_AM1SU);
        run_md("divu_0",   F3_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1);
        run_md("rem_0",    F3_REM,    32'd7,         32'd0,         32'd7,         1);
        run_md("div_ovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem_neg",  F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_md("div_neg",  F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_md("remu",     F3_REMU,   32'd100,       32'd7,         32'd2,         33);

        // Flush at T+10 of a divide
        drive_md(F3_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("flush_stall", bus.md_stall, 1'b0);
        check("flush_md_sel", bus.md_sel, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.md_sel) pulses++;
        end
        check("flush_no_pulse", pulses, 0);
        @(posedge clk); #1;
        run_md("mul_after_flush", F3_MUL, 32'd2, 32'd3, 32'd6, LAT_A2);

        // Reset asserted at T+5 of a divide
        drive_md(F3_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check("rst_mid_stall", bus.md_stall, 1'b0);
        check("rst_mid_md_sel", bus.md_sel, 1'b0);
        check("rst_mid_md_result", bus.md_result, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive_idle();
        run_md("mul_after_reset", F3_MUL, 32'd2, 32'd3, 32'd6, LAT_A2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
